// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor.
// Contents: saturating counter type, BTB entry layout, counter reset value,
// and the saturating counter update helper.
package branch_predictor_pkg;

  localparam int unsigned BP_DATA_W  = 32;
  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_W   = BP_DATA_W - BP_IDX_W - 2;

  typedef logic [1:0] bp_ctr_t;

  // Weakly not-taken
  localparam bp_ctr_t PHT_RESET = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_DATA_W-1:0] target;
    logic                 is_cond;
  } btb_entry_t;

  // 2-bit saturating counter step: +1 on taken, -1 on not taken, clamped
  function automatic bp_ctr_t sat_update(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t res;
    res = ctr;
    if (taken && (ctr != 2'b11)) begin
      res = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped branch target buffer storage.
// Two asynchronous read ports (fetch lookup, execute hit check), one
// synchronous write port. Only the valid bits are reset; tag/target/is_cond
// content is meaningless while valid is low.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_rd0_idx/o_rd0_entry   read port 0
//   i_rd1_idx/o_rd1_entry   read port 1
//   i_wr_en/i_wr_idx/i_wr_entry  write port (entry.valid=0 invalidates)
module branch_predictor_btb_array
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] i_rd0_idx,
  output btb_entry_t                 o_rd0_entry,
  input  logic [$clog2(ENTRIES)-1:0] i_rd1_idx,
  output btb_entry_t                 o_rd1_entry,
  input  logic                       i_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
  input  btb_entry_t                 i_wr_entry
);

  logic [ENTRIES-1:0]   r_valid;
  logic [ENTRIES-1:0]   r_is_cond;
  logic [BP_TAG_W-1:0]  r_tag    [ENTRIES];
  logic [BP_DATA_W-1:0] r_target [ENTRIES];

  // Valid bits: async reset, so a reset during a write leaves the entry invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= i_wr_entry.valid;
    end
  end

  // Payload storage, no reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]     <= i_wr_entry.tag;
      r_target[i_wr_idx]  <= i_wr_entry.target;
      r_is_cond[i_wr_idx] <= i_wr_entry.is_cond;
    end
  end

  assign o_rd0_entry = {r_valid[i_rd0_idx], r_tag[i_rd0_idx],
                        r_target[i_rd0_idx], r_is_cond[i_rd0_idx]};
  assign o_rd1_entry = {r_valid[i_rd1_idx], r_tag[i_rd1_idx],
                        r_target[i_rd1_idx], r_is_cond[i_rd1_idx]};

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the fetch stage: direct-mapped BTB plus a
// table of 2-bit saturating counters (PHT). Lookup and mispredict/redirect
// are combinational; execute-stage resolves update the tables on the edge.
// Build option: define GSHARE_EN to XOR a global history register into the
// PHT index (BTB stays PC-indexed). Default build uses the PC index only.
// Ports:
//   clk, rst                      clock, async active-high reset
//   pc_f                          fetch PC
//   predict_taken_f, next_pc_f    prediction for pc_f
//   predict_idx_f                 PHT index used, carried to execute
//   resolve_*_e                   resolved execute-stage instruction
//   predicted_taken_e/target_e    prediction carried to execute
//   mispredict_e, redirect_pc_e   flush request and correct next PC
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BP_DATA_W,
  parameter int unsigned ENTRIES    = BP_ENTRIES,
  parameter int unsigned HIST_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      pc_f,
  output logic                       predict_taken_f,
  output logic [DATA_WIDTH-1:0]      next_pc_f,
  output logic [$clog2(ENTRIES)-1:0] predict_idx_f,
  input  logic                       resolve_valid_e,
  input  logic                       resolve_ctrl_e,
  input  logic                       resolve_cond_e,
  input  logic [DATA_WIDTH-1:0]      resolve_pc_e,
  input  logic                       resolve_taken_e,
  input  logic [DATA_WIDTH-1:0]      resolve_target_e,
  input  logic [$clog2(ENTRIES)-1:0] resolve_idx_e,
  input  logic                       predicted_taken_e,
  input  logic [DATA_WIDTH-1:0]      predicted_target_e,
  output logic                       mispredict_e,
  output logic [DATA_WIDTH-1:0]      redirect_pc_e
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]            w_fidx;
  logic [DATA_WIDTH-IDX_W-3:0] w_ftag;
  logic [IDX_W-1:0]            w_ridx;
  logic [DATA_WIDTH-IDX_W-3:0] w_rtag;
  btb_entry_t                  w_fentry;
  btb_entry_t                  w_rentry;
  btb_entry_t                  w_wr_entry;
  logic                        w_fhit;
  logic                        w_rhit;
  logic                        w_wr_en;
  logic                        w_pht_upd;
  logic [IDX_W-1:0]            w_pht_idx;
  bp_ctr_t                     w_fctr;
  logic                        w_unused;

  bp_ctr_t r_pht [ENTRIES];

  assign w_fidx = pc_f[IDX_W+1:2];
  assign w_ftag = pc_f[DATA_WIDTH-1:IDX_W+2];
  assign w_ridx = resolve_pc_e[IDX_W+1:2];
  assign w_rtag = resolve_pc_e[DATA_WIDTH-1:IDX_W+2];

  branch_predictor_btb_array #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd0_idx   (w_fidx),
    .o_rd0_entry (w_fentry),
    .i_rd1_idx   (w_ridx),
    .o_rd1_entry (w_rentry),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_ridx),
    .i_wr_entry  (w_wr_entry)
  );

  // Fetch lookup; suppressed while in reset
  assign w_fhit          = w_fentry.valid && (w_fentry.tag == w_ftag);
  assign w_fctr          = r_pht[predict_idx_f];
  assign predict_taken_f = !rst && w_fhit && (!w_fentry.is_cond || w_fctr[1]);
  assign next_pc_f       = predict_taken_f ? w_fentry.target
                                           : pc_f + DATA_WIDTH'(4);

  // Resolve: flush when the carried prediction disagrees with the outcome
  always_comb begin
    mispredict_e = 1'b0;
    if (resolve_valid_e) begin
      if (resolve_ctrl_e) begin
        mispredict_e = (resolve_taken_e != predicted_taken_e) ||
                       (resolve_taken_e && predicted_taken_e &&
                        (resolve_target_e != predicted_target_e));
      end else begin
        // Non-control instruction predicted taken: stale BTB entry
        mispredict_e = predicted_taken_e;
      end
    end
  end

  assign redirect_pc_e = (resolve_ctrl_e && resolve_taken_e) ? resolve_target_e
                                                             : resolve_pc_e + DATA_WIDTH'(4);

  // BTB write: allocate/retarget on taken control flow, invalidate stale hits
  assign w_rhit     = w_rentry.valid && (w_rentry.tag == w_rtag);
  assign w_wr_en    = resolve_valid_e &&
                      ((resolve_ctrl_e && resolve_taken_e) || (!resolve_ctrl_e && w_rhit));
  assign w_wr_entry = resolve_ctrl_e ? {1'b1, w_rtag, resolve_target_e, resolve_cond_e}
                                     : '0;

  assign w_pht_upd = resolve_valid_e && resolve_ctrl_e && resolve_cond_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_pht[i] <= PHT_RESET;
      end
    end else if (w_pht_upd) begin
      r_pht[w_pht_idx] <= sat_update(r_pht[w_pht_idx], resolve_taken_e);
    end
  end

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;

  // Non-speculative history: shifts only on resolved conditional branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_pht_upd) begin
      r_ghr <= HIST_BITS'({r_ghr, resolve_taken_e});
    end
  end

  assign predict_idx_f = w_fidx ^ IDX_W'(r_ghr);
  assign w_pht_idx     = resolve_idx_e;
  assign w_unused      = ^{w_rentry.target, w_rentry.is_cond};
`else
  assign predict_idx_f = w_fidx;
  assign w_pht_idx     = w_ridx;
  assign w_unused      = ^{w_rentry.target, w_rentry.is_cond, resolve_idx_e};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized resolve/fetch traffic, checked against a table-level model.
module tb_branch_predictor;

  localparam int unsigned DW  = 32;
  localparam int unsigned ENT = 16;
  localparam int unsigned HB  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pc_f;
  logic          predict_taken_f;
  logic [DW-1:0] next_pc_f;
  logic [3:0]    predict_idx_f;
  logic          resolve_valid_e;
  logic          resolve_ctrl_e;
  logic          resolve_cond_e;
  logic [DW-1:0] resolve_pc_e;
  logic          resolve_taken_e;
  logic [DW-1:0] resolve_target_e;
  logic [3:0]    resolve_idx_e;
  logic          predicted_taken_e;
  logic [DW-1:0] predicted_target_e;
  logic          mispredict_e;
  logic [DW-1:0] redirect_pc_e;

  int n_cmp = 0;
  int n_err = 0;

  // Reference tables
  bit            m_valid [ENT];
  logic [DW-1:0] m_tag   [ENT];
  logic [DW-1:0] m_tgt   [ENT];
  bit            m_cond  [ENT];
  int            m_pht   [ENT];
  int            m_ghr;

  branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(ENT), .HIST_BITS(HB)) dut (
    .clk                (clk),
    .rst                (rst),
    .pc_f               (pc_f),
    .predict_taken_f    (predict_taken_f),
    .next_pc_f          (next_pc_f),
    .predict_idx_f      (predict_idx_f),
    .resolve_valid_e    (resolve_valid_e),
    .resolve_ctrl_e     (resolve_ctrl_e),
    .resolve_cond_e     (resolve_cond_e),
    .resolve_pc_e       (resolve_pc_e),
    .resolve_taken_e    (resolve_taken_e),
    .resolve_target_e   (resolve_target_e),
    .resolve_idx_e      (resolve_idx_e),
    .predicted_taken_e  (predicted_taken_e),
    .predicted_target_e (predicted_target_e),
    .mispredict_e       (mispredict_e),
    .redirect_pc_e      (redirect_pc_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int f_idx(input logic [DW-1:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int f_pidx(input logic [DW-1:0] pc);
`ifdef GSHARE_EN
    return f_idx(pc) ^ m_ghr;
`else
    return f_idx(pc);
`endif
  endfunction

  function automatic bit f_hit(input logic [DW-1:0] pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == (pc / 64));
  endfunction

  function automatic bit f_ptaken(input logic [DW-1:0] pc);
    if (rst) return 1'b0;
    return f_hit(pc) && (!m_cond[f_idx(pc)] || (m_pht[f_pidx(pc)] >= 2));
  endfunction

  function automatic logic [DW-1:0] f_pnext(input logic [DW-1:0] pc);
    logic [DW-1:0] seq;
    seq = pc + 32'd4;
    return f_ptaken(pc) ? m_tgt[f_idx(pc)] : seq;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0;
      m_pht[i]   = 1;
    end
    m_ghr = 0;
  endtask

  // Compare every output against the model mid-cycle
  task automatic sample_check();
    bit            exp_mp;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    if (!resolve_valid_e)     exp_mp = 1'b0;
    else if (resolve_ctrl_e)  exp_mp = (resolve_taken_e != predicted_taken_e) ||
                                       (resolve_taken_e && predicted_taken_e &&
                                        (resolve_target_e != predicted_target_e));
    else                      exp_mp = predicted_taken_e;
    exp_rd = (resolve_ctrl_e && resolve_taken_e) ? resolve_target_e : resolve_pc_e + 32'd4;
    check("predict_taken_f", 64'(predict_taken_f), 64'(f_ptaken(pc_f)));
    check("next_pc_f",       64'(next_pc_f),       64'(f_pnext(pc_f)));
    check("predict_idx_f",   64'(predict_idx_f),   64'(f_pidx(pc_f) % ENT));
    check("mispredict_e",    64'(mispredict_e),    64'(exp_mp));
    check("redirect_pc_e",   64'(redirect_pc_e),   64'(exp_rd));
  endtask

  // Clock edge: apply the resolve to the model tables
  task automatic advance();
    int  i;
    int  p;
    bit  hit;
    @(posedge clk);
    if (!rst && resolve_valid_e) begin
      i   = f_idx(resolve_pc_e);
      hit = f_hit(resolve_pc_e);
      if (resolve_ctrl_e && resolve_taken_e) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = resolve_pc_e / 64;
        m_tgt[i]   = resolve_target_e;
        m_cond[i]  = resolve_cond_e;
      end
      if (!resolve_ctrl_e && hit) m_valid[i] = 1'b0;
      if (resolve_ctrl_e && resolve_cond_e) begin
`ifdef GSHARE_EN
        p = int'(resolve_idx_e);
`else
        p = i;
`endif
        m_pht[p] = resolve_taken_e ? ((m_pht[p] == 3) ? 3 : m_pht[p] + 1)
                                   : ((m_pht[p] == 0) ? 0 : m_pht[p] - 1);
        m_ghr = (m_ghr * 2 + int'(resolve_taken_e)) % (1 << HB);
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit c, input bit cd, input logic [DW-1:0] pc,
                       input bit t, input logic [DW-1:0] tg,
                       input bit pt, input logic [DW-1:0] ptg);
    resolve_valid_e    = v;
    resolve_ctrl_e     = c;
    resolve_cond_e     = cd;
    resolve_pc_e       = pc;
    resolve_taken_e    = t;
    resolve_target_e   = tg;
    resolve_idx_e      = 4'(f_pidx(pc));
    predicted_taken_e  = pt;
    predicted_target_e = ptg;
  endtask

  // Resolve carrying exactly what fetch would have predicted for pc
  task automatic resolve_pred(input logic [DW-1:0] pc, input bit c, input bit cd,
                              input bit t, input logic [DW-1:0] tg);
    drive(1'b1, c, cd, pc, t, tg, f_ptaken(pc), f_pnext(pc));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Hand-derived expectations for the PC-indexed build
  task automatic chk_f(input string t, input bit tk, input logic [DW-1:0] nx);
`ifndef GSHARE_EN
    check({t, "_taken"}, 64'(predict_taken_f), 64'(tk));
    check({t, "_next"},  64'(next_pc_f),       64'(nx));
`endif
  endtask

  task automatic chk_m(input string t, input bit mp, input logic [DW-1:0] rd);
    check({t, "_mp"},    64'(mispredict_e),  64'(mp));
    check({t, "_redir"}, 64'(redirect_pc_e), 64'(rd));
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    idle();
    pc_f = 32'h40;
    sample_check(); chk_f("in_reset", 1'b0, 32'h44);
    advance(); advance();
    rst = 1'b0;
    sample_check(); chk_f("post_reset", 1'b0, 32'h44);
    advance();

    // First allocation, lookup in same cycle still sees the empty entry
    pc_f = 32'h100;
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    sample_check(); chk_m("alloc", 1'b1, 32'h80); chk_f("no_bypass", 1'b0, 32'h104);
    advance();
    idle();
    sample_check(); chk_f("alloc_hit", 1'b1, 32'h80);
    advance();

    // Saturate, then two not-takens flip the prediction
    repeat (4) begin resolve_pred(32'h100, 1'b1, 1'b1, 1'b1, 32'h80); sample_check(); advance(); end
    resolve_pred(32'h100, 1'b1, 1'b1, 1'b0, 32'h80); sample_check(); advance();
    idle(); sample_check(); chk_f("nt1_hold", 1'b1, 32'h80); advance();
    resolve_pred(32'h100, 1'b1, 1'b1, 1'b0, 32'h80); sample_check(); advance();
    idle(); sample_check(); chk_f("nt2_flip", 1'b0, 32'h104); advance();

    // Alias on index 0 replaces the old entry
    resolve_pred(32'h140, 1'b1, 1'b1, 1'b1, 32'h200); sample_check(); advance();
    idle(); pc_f = 32'h100;
    sample_check(); chk_f("alias_old", 1'b0, 32'h104); advance();
    pc_f = 32'h140;
    sample_check(); chk_f("alias_new", 1'b1, 32'h200); advance();

    // JAL then JALR retarget; unconditional entry ignores the PHT
    pc_f = 32'h20;
    drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h300, 1'b0, 32'h24);
    sample_check(); chk_m("jal", 1'b1, 32'h300); advance();
    drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h310, 1'b1, 32'h300);
    sample_check(); chk_m("jalr", 1'b1, 32'h310); chk_f("jalr_old", 1'b1, 32'h300); advance();
    drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h310, 1'b1, 32'h310);
    sample_check(); chk_m("jalr_ok", 1'b0, 32'h310); chk_f("jalr_new", 1'b1, 32'h310); advance();

    // Stale entry on a non-control instruction
    pc_f = 32'h140;
    drive(1'b1, 1'b0, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h200);
    sample_check(); chk_m("stale", 1'b1, 32'h144); advance();
    idle(); sample_check(); chk_f("stale_clr", 1'b0, 32'h144); advance();

    // Invalid resolve never flushes
    drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    sample_check(); chk_m("invalid", 1'b0, 32'h80); advance();

    // PC+4 wraps
    idle(); pc_f = 32'hFFFF_FFFC;
    sample_check(); chk_f("wrap", 1'b0, 32'h0); advance();

    // Reset during an update: write is lost, mispredict stays combinational
    pc_f = 32'h20;
    drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h500, 1'b1, 32'h310);
    rst = 1'b1; model_reset();
    sample_check(); chk_f("rst_pred", 1'b0, 32'h24); chk_m("rst_comb", 1'b1, 32'h500);
    advance();
    rst = 1'b0; idle();
    sample_check(); chk_f("rst_abort", 1'b0, 32'h24); advance();

    // Random traffic over a small PC pool to force hits and aliases
    for (int n = 0; n < 600; n++) begin
      logic [DW-1:0] rpc;
      logic [DW-1:0] tgt;
      rpc = 32'h1000 + 32'($urandom_range(0, 2) * 64) + 32'($urandom_range(0, 15) * 4);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) < 7)
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, 1'($urandom),
              rpc, 1'($urandom), tgt, f_ptaken(rpc), f_pnext(rpc));
      else
        drive($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom),
              rpc, 1'($urandom), tgt, 1'($urandom), $urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) < 2) tgt = $urandom & 32'hFFFF_FFFC;
      pc_f = ($urandom_range(0, 9) < 8)
           ? 32'h1000 + 32'($urandom_range(0, 2) * 64) + 32'($urandom_range(0, 15) * 4)
           : ($urandom & 32'hFFFF_FFFC);
      sample_check();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage of the 5-stage pipelined core. It replaces static "always PC+4" fetch with a direct-mapped branch target buffer (BTB) and a table of 2-bit saturating counters (PHT). Fetch looks it up combinationally every cycle. The execute stage feeds back resolved outcomes, which update the tables and produce a mispredict/redirect for the pipeline flush logic.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC and target buses
- ENTRIES, 16, BTB/PHT depth; power of two, ≥ 2; IDX_W = log2(ENTRIES)
- HIST_BITS, 4, global history length; 1 ≤ HIST_BITS ≤ IDX_W; used only with GSHARE_EN

Ports:
- clk  in  1  clock; rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- pc_f  in  DATA_WIDTH  fetch PC
- predict_taken_f  out  1  predicted taken
- next_pc_f  out  DATA_WIDTH  predicted next PC
- predict_idx_f  out  IDX_W  PHT index used; carried down the pipeline
- resolve_valid_e  in  1  valid instruction in execute
- resolve_ctrl_e  in  1  instruction is branch/JAL/JALR
- resolve_cond_e  in  1  conditional branch (0 = unconditional jump)
- resolve_pc_e  in  DATA_WIDTH  PC of the execute instruction
- resolve_taken_e  in  1  actual outcome
- resolve_target_e  in  DATA_WIDTH  actual target
- resolve_idx_e  in  IDX_W  predict_idx_f carried to execute
- predicted_taken_e  in  1  prediction carried to execute
- predicted_target_e  in  DATA_WIDTH  next_pc_f carried to execute
- mispredict_e  out  1  flush request
- redirect_pc_e  out  DATA_WIDTH  correct next PC

## Operation
- Index bits: idx = pc[IDX_W+1:2]. Tag bits: pc[DATA_WIDTH-1:IDX_W+2]. BTB entry fields: valid, tag, target, is_cond.
- Lookup: hit = valid[idx] & tag match. predict_taken_f = hit & (!is_cond | pht[predict_idx_f][1]). next_pc_f = predict_taken_f ? target : pc_f+4, wrapping modulo 2^DATA_WIDTH.
- Mispredict, valid & ctrl: resolve_taken_e ≠ predicted_taken_e, or both taken and resolve_target_e ≠ predicted_target_e.
- Mispredict, valid & !ctrl: predicted_taken_e = 1 (stale entry).
- redirect_pc_e = (ctrl & resolve_taken_e) ? resolve_target_e : resolve_pc_e+4.
- mispredict_e = 0 whenever resolve_valid_e = 0.
- Update on the clock edge when resolve_valid_e = 1:
  - ctrl, taken: write BTB[idx] ← {1, tag, resolve_target_e, resolve_cond_e}. Allocation on miss replaces the old entry; there is no victim check.
  - ctrl, not taken, hit: BTB unchanged. Not taken, miss: no allocation.
  - ctrl & cond: PHT[resolve_idx_e] saturating +1 if taken, −1 if not; clamps at 2'b11 and 2'b00.
  - !ctrl & BTB hit: clear valid[idx].
- Reset: all valid = 0, PHT = 2'b01 (weakly not-taken), GHR = 0. While rst is high: predict_taken_f = 0, next_pc_f = pc_f+4, mispredict_e combinational from its inputs. Reset mid-update aborts the write; the reset state wins.

## Timing
- Lookup and mispredict/redirect are combinational, 0 cycles.
- Table writes become visible to lookup the cycle after the resolve edge.
- No write-to-read bypass: a lookup in the same cycle as a write to the same index sees the old contents.
- No handshake and no stall input. The block holds no per-fetch state; pipeline stalls only hold the carried fields.

## Configuration
- GSHARE_EN defined: predict_idx_f = pc idx XOR {zero-pad, GHR}. GHR is a HIST_BITS shift register; each conditional resolve shifts in resolve_taken_e at the LSB, non-speculatively. The BTB is always indexed by PC bits.
- GSHARE_EN undefined: predict_idx_f = pc idx, PHT updates use the resolve_pc_e index, resolve_idx_e is ignored, and no GHR is present.

## Structure
- types_pkg additions: bp_ctr_t (2-bit), btb_entry_t struct (valid, tag, target, is_cond), PHT_RESET = 2'b01, a sat_update function.
- One sub-module, btb_array: storage with asynchronous read, one synchronous write port, async-reset valid bits. PHT and GHR stay in the top.

## Test plan
Values below use ENTRIES=16: idx = pc[5:2], tag = pc[31:6].
- Reset, then pc_f=0x40 -> predict_taken_f=0, next_pc_f=0x44.
- Conditional branch at 0x100, target 0x80, resolved taken with predicted_taken_e=0 -> mispredict_e=1, redirect_pc_e=0x80; next cycle pc_f=0x100 -> taken, next_pc_f=0x80.
- Train 0x100 taken ×4, then not-taken ×1 -> still predicts 0x80; a second not-taken -> predicts 0x104.
- Alias: allocate 0x100, then resolve 0x140 taken to 0x200 (same idx 0) -> pc_f=0x100 misses (next_pc_f 0x104); pc_f=0x140 -> 0x200.
- JAL at 0x20 to 0x300, then JALR at 0x20 resolved to 0x310 with predicted_target_e=0x300 -> mispredict_e=1, redirect 0x310, entry retargeted; prediction ignores the PHT.
- Stale entry: resolve_ctrl_e=0 at 0x100 with predicted_taken_e=1 -> mispredict_e=1, redirect 0x104; next cycle pc_f=0x100 misses.
